// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a word FIFO
// Words are queued on TX_en and serialised as start, data (LSB first), optional parity, stop bits.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset_b,
  input  logic                          TX_en,
  input  logic [DATA_BITS-1:0]          TX_Data_in,
  output logic                          TX_Ready,
  output logic                          RsTx,
  output logic                          TX_Busy,
  output logic                          TX_Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_Count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] head, shreg;
  logic [BW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 par_bit;
  logic                 push, pop, not_empty, bit_end, last_stop;
  state_t               state;

  assign not_empty = FIFO_Count != '0;
  // Fullness is judged on the registered count only, so a same-cycle pop never rescues a write.
  assign TX_Ready  = FIFO_Count < (AW+1)'(FIFO_DEPTH);
  assign push      = TX_en & TX_Ready;
  assign head      = mem[rd_ptr];
  assign bit_end   = baud_cnt == BW'(CLKS_PER_BIT-1);
  assign last_stop = stop_idx == 1'(STOP_BITS-1);
  assign pop       = not_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end & last_stop));
  assign TX_Busy   = state != S_IDLE;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= TX_Data_in;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      FIFO_Count  <= '0;
      TX_Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      FIFO_Count <= FIFO_Count + (AW+1)'(1);
      else if (pop && !push) FIFO_Count <= FIFO_Count - (AW+1)'(1);
      if (TX_en && !TX_Ready) TX_Overflow <= 1'b1;
    end
  end

  // RsTx is a registered copy of the current state's bit, so the line trails the state by one clock.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      RsTx     <= 1'b1;
    end else begin
      if (state == S_IDLE || bit_end) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + BW'(1);

      case (state)
        S_START: RsTx <= 1'b0;
        S_DATA:  RsTx <= shreg[0];
        S_PAR:   RsTx <= par_bit;
        default: RsTx <= 1'b1;
      endcase

      if (pop) begin
        shreg   <= head;
        par_bit <= (^head) ^ (PARITY == 1);
        state   <= S_START;
      end else begin
        case (state)
          S_IDLE: state <= S_IDLE;
          S_START: if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
          S_DATA: if (bit_end) begin
            shreg <= shreg >> 1;
            if (bit_idx == IW'(DATA_BITS-1)) begin
              state    <= (PARITY != 0) ? S_PAR : S_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
          S_PAR: if (bit_end) begin
            state    <= S_STOP;
            stop_idx <= 1'b0;
          end
          S_STOP: if (bit_end) begin
            if (last_stop) state <= S_IDLE;
            else           stop_idx <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed and random checks of uart_tx_fifo
// Three instances: 8E1, 7O2 and 8N1, all 4 clocks per bit with a 4-word FIFO.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset_b = 1'b0;
  logic       en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
  logic [7:0] din_a = '0, din_c = '0;
  logic [6:0] din_b = '0;
  logic       ready_a, ready_b, ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;
  int         total = 0, bad = 0;
  int         busy_cnt_a = 0, busy_cnt_b = 0, busy_cnt_c = 0;

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset_b(reset_b), .TX_en(en_a), .TX_Data_in(din_a), .TX_Ready(ready_a),
    .RsTx(tx_a), .TX_Busy(busy_a), .TX_Overflow(ovf_a), .FIFO_Count(cnt_a));
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset_b(reset_b), .TX_en(en_b), .TX_Data_in(din_b), .TX_Ready(ready_b),
    .RsTx(tx_b), .TX_Busy(busy_b), .TX_Overflow(ovf_b), .FIFO_Count(cnt_b));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .reset_b(reset_b), .TX_en(en_c), .TX_Data_in(din_c), .TX_Ready(ready_c),
    .RsTx(tx_c), .TX_Busy(busy_c), .TX_Overflow(ovf_c), .FIFO_Count(cnt_c));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
    if (busy_b) busy_cnt_b <= busy_cnt_b + 1;
    if (busy_c) busy_cnt_c <= busy_cnt_c + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line_of(input int w);
    case (w)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  // Expected line levels, one entry per bit period, index 0 is the start bit.
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nd, input int par, input int ns);
    logic [15:0] f;
    int pos, ones;
    f = '0; pos = 1; ones = 0;
    for (int i = 0; i < nd; i++) begin
      f[pos] = d[i];
      ones += int'(d[i]);
      pos++;
    end
    if (par != 0) begin
      f[pos] = (par == 2) ? 1'(ones % 2) : 1'(1 - ones % 2);
      pos++;
    end
    for (int i = 0; i < ns; i++) begin
      f[pos] = 1'b1;
      pos++;
    end
    return f;
  endfunction

  task automatic capture_check(input int w, input logic [8:0] word, input int max_wait, input string tag);
    int nd, par, ns, nbits, waited, unstable;
    logic [15:0] got, exp;
    logic v;
    nd  = (w == 1) ? 7 : 8;
    par = (w == 0) ? 2 : (w == 1) ? 1 : 0;
    ns  = (w == 1) ? 2 : 1;
    exp = frame_bits(word, nd, par, ns);
    nbits = 1 + nd + ((par != 0) ? 1 : 0) + ns;
    waited = 0; unstable = 0; got = '0;
    do begin
      @(negedge clk);
      waited++;
    end while (line_of(w) !== 1'b0 && waited < max_wait);
    check({tag, "_start"}, 32'(line_of(w)), 32'd0);
    if (line_of(w) !== 1'b0) return;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        v = line_of(w);
        if (c == 0) got[i] = v;
        else if (v !== got[i]) unstable++;
      end
    end
    check({tag, "_bits"}, 32'(got), 32'(exp));
    check({tag, "_stable"}, 32'(unstable), 32'd0);
  endtask

  task automatic do_write(input int w, input logic [8:0] d);
    case (w)
      0:       begin en_a = 1'b1; din_a = d[7:0]; end
      1:       begin en_b = 1'b1; din_b = d[6:0]; end
      default: begin en_c = 1'b1; din_c = d[7:0]; end
    endcase
    @(posedge clk);
    #1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    din_a = 8'($urandom); din_b = 7'($urandom); din_c = 8'($urandom);
  endtask

  initial begin
    logic [8:0] d;
    logic [7:0] burst [11];
    int b0, lows, busys;

    repeat (3) @(negedge clk);
    check("rst_tx_a", 32'(tx_a), 32'd1);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_ovf_a", 32'(ovf_a), 32'd0);
    check("rst_cnt_a", 32'(cnt_a), 32'd0);
    check("rst_ready_a", 32'(ready_a), 32'd1);
    check("rst_tx_c", 32'(tx_c), 32'd1);

    // 8N1: write on the first edge after release, line falls two edges later
    @(negedge clk);
    reset_b = 1'b1;
    b0 = busy_cnt_c;
    do_write(2, 9'h41);
    check("first_write_cnt", 32'(cnt_c), 32'd1);
    @(negedge clk);
    check("lat_idle0", 32'(tx_c), 32'd1);
    @(negedge clk);
    check("lat_idle1", 32'(tx_c), 32'd1);
    check("lat_busy", 32'(busy_c), 32'd1);
    capture_check(2, 9'h41, 1, "frame_41");
    repeat (6) @(negedge clk);
    check("busy_len_c", 32'(busy_cnt_c - b0), 32'd40);
    check("idle_c", 32'(tx_c), 32'd1);

    // 8N1 back-to-back frames with no idle gap
    en_c = 1'b1; din_c = 8'h41;
    @(posedge clk); #1;
    din_c = 8'h46;
    @(posedge clk); #1;
    en_c = 1'b0; din_c = 8'($urandom);
    capture_check(2, 9'h41, 4, "b2b_first");
    capture_check(2, 9'h46, 1, "b2b_second");

    // parity modes and two stop bits
    b0 = busy_cnt_a;
    do_write(0, 9'h46);
    capture_check(0, 9'h46, 4, "even_46");
    repeat (6) @(negedge clk);
    check("busy_len_a", 32'(busy_cnt_a - b0), 32'd44);
    b0 = busy_cnt_b;
    do_write(1, 9'h46);
    capture_check(1, 9'h46, 4, "odd_46");
    repeat (6) @(negedge clk);
    check("busy_len_b", 32'(busy_cnt_b - b0), 32'd44);

    for (int r = 0; r < 6; r++) begin
      d = 9'($urandom);
      do_write(r % 3, d);
      capture_check(r % 3, d, 4, "rand");
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    // 11 back-to-back writes into a depth-4 FIFO while idle
    for (int k = 0; k < 11; k++) burst[k] = 8'($urandom);
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 11; k++) begin
          int e;
          en_a = 1'b1; din_a = burst[k];
          @(posedge clk); #1;
          e = (k == 0) ? 1 : (k < 4) ? k : 4;
          check("burst_cnt", 32'(cnt_a), 32'(e));
          check("burst_ready", 32'(ready_a), 32'(e < 4));
          check("burst_ovf", 32'(ovf_a), 32'(k >= 5));
        end
        en_a = 1'b0; din_a = 8'($urandom);
      end
      begin
        capture_check(0, {1'b0, burst[0]}, 6, "burst_f0");
        for (int k = 1; k < 5; k++) capture_check(0, {1'b0, burst[k]}, 1, "burst_fn");
      end
    join
    lows = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_a !== 1'b1) lows++;
    end
    check("burst_no_extra", 32'(lows), 32'd0);
    check("ovf_sticky", 32'(ovf_a), 32'd1);
    check("ovf_b_clear", 32'(ovf_b), 32'd0);

    // asynchronous reset during data bit 3 with two words queued
    d = 9'($urandom) & 9'h0f7;
    en_a = 1'b1; din_a = d[7:0];
    @(posedge clk); #1;
    din_a = 8'($urandom);
    @(posedge clk); #1;
    din_a = 8'($urandom);
    @(posedge clk); #1;
    en_a = 1'b0;
    repeat (18) @(negedge clk);
    check("pre_rst_cnt", 32'(cnt_a), 32'd2);
    check("pre_rst_busy", 32'(busy_a), 32'd1);
    check("pre_rst_bit3", 32'(tx_a), 32'd0);
    reset_b = 1'b0;
    #1;
    check("arst_tx", 32'(tx_a), 32'd1);
    check("arst_cnt", 32'(cnt_a), 32'd0);
    check("arst_busy", 32'(busy_a), 32'd0);
    check("arst_ovf", 32'(ovf_a), 32'd0);
    check("arst_ready", 32'(ready_a), 32'd1);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    lows = 0; busys = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_a !== 1'b1) lows++;
      if (busy_a !== 1'b0) busys++;
    end
    check("post_rst_line", 32'(lows), 32'd0);
    check("post_rst_busy", 32'(busys), 32'd0);
    check("post_rst_cnt", 32'(cnt_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
